// File: rtl/voxel_led_pkg.sv
// Shared constants, types and helpers for the LED-driver grayscale path
// (packer and serializer).
package voxel_led_pkg;

  localparam int LEDS_PER_DRIVER = 16;
  localparam int IN_BITS         = 8;
  localparam int GS_BITS         = 16;
  localparam int LED_FIELD       = 3 * GS_BITS;
  localparam int LATCH_SIZE      = LED_FIELD * LEDS_PER_DRIVER + 1;
  localparam int GS_SELECT_BIT   = LATCH_SIZE - 1;
  localparam int SLOT_W          = $clog2(LEDS_PER_DRIVER);

  // Value of the select bit: 0 = grayscale latch, 1 = control latch.
  localparam logic GS_SELECT   = 1'b0;
  localparam logic CTRL_SELECT = 1'b1;

  typedef logic [LATCH_SIZE-1:0] latch_word_t;
  typedef logic [SLOT_W-1:0]     slot_idx_t;
  typedef logic [LED_FIELD-1:0]  led_field_t;

  // Replicating the byte maps 0x00 -> 0x0000 and 0xFF -> 0xFFFF exactly.
  function automatic logic [GS_BITS-1:0] expand8to16(input logic [IN_BITS-1:0] c);
    return {c, c};
  endfunction

  // One LED field: B in the top 16 bits, R in the bottom 16 bits.
  function automatic led_field_t pack_led(input logic [3*IN_BITS-1:0] rgb);
    return {expand8to16(rgb[7:0]), expand8to16(rgb[15:8]), expand8to16(rgb[23:16])};
  endfunction

endpackage

// File: rtl/gs_latch_packer.sv
// Assembles 16 RGB pixels into one 769-bit grayscale latch word and hands it
// to the serializer over valid/ready, double-buffered against pixel intake.
module gs_latch_packer
  import voxel_led_pkg::*;
(
  input  logic              CLK_10M,
  input  logic              nReset,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic              pix_sof,
  input  logic [23:0]       pix_rgb,
  output logic              gs_valid,
  input  logic              gs_ready,
  output logic [LATCH_SIZE-1:0] gs_word,
  output logic [7:0]        drop_count
);

  localparam slot_idx_t LAST_SLOT = slot_idx_t'(LEDS_PER_DRIVER - 1);
  localparam slot_idx_t SLOT_ONE  = slot_idx_t'(1);

  logic [LATCH_SIZE-2:0] asm_word;
  slot_idx_t             idx;
  slot_idx_t             wr_slot;
  logic                  asm_full;
  logic                  pix_accept;
  logic                  restart;
  logic                  xfer;

  assign pix_ready  = !asm_full;
  assign pix_accept = pix_valid && pix_ready;
  assign restart    = pix_sof && (idx != '0);
  assign wr_slot    = restart ? '0 : idx;
  assign xfer       = asm_full && (!gs_valid || gs_ready);

  // Assembly buffer is pure datapath: every slot is rewritten before use.
  always_ff @(posedge CLK_10M) begin
    if (pix_accept) begin
      asm_word[LED_FIELD*int'(wr_slot) +: LED_FIELD] <= pack_led(pix_rgb);
    end
  end

  // Accept and transfer are mutually exclusive: accept needs !asm_full,
  // transfer needs asm_full, so asm_full never has two writers on one edge.
  always_ff @(posedge CLK_10M) begin
    if (!nReset) begin
      idx        <= '0;
      asm_full   <= 1'b0;
      gs_valid   <= 1'b0;
      gs_word    <= '0;
      drop_count <= '0;
    end else begin
      if (pix_accept) begin
        if (restart) begin
          idx <= SLOT_ONE;
          if (drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
          end
        end else begin
          idx <= idx + 1'b1;
          if (idx == LAST_SLOT) begin
            asm_full <= 1'b1;
          end
        end
      end

      if (xfer) begin
        gs_word  <= {GS_SELECT, asm_word};
        gs_valid <= 1'b1;
        asm_full <= 1'b0;
      end else if (gs_ready) begin
        gs_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gs_latch_packer.sv
// Scenario bench for gs_latch_packer: expected latch words are queued at
// stimulus time and popped by a negedge monitor when each new word appears.
module tb_gs_latch_packer;
  import voxel_led_pkg::*;

  logic              CLK_10M = 1'b0;
  logic              nReset = 1'b0;
  logic              pix_valid = 1'b0;
  logic              pix_ready;
  logic              pix_sof = 1'b0;
  logic [23:0]       pix_rgb = '0;
  logic              gs_valid;
  logic              gs_ready = 1'b0;
  logic [LATCH_SIZE-1:0] gs_word;
  logic [7:0]        drop_count;

  int          tests_run = 0;
  int          tests_failed = 0;
  latch_word_t exp_q[$];
  latch_word_t mon_exp;
  logic        seen_word = 1'b0;
  logic [23:0] grp[16];
  int          exp_drop = 0;

  gs_latch_packer dut (
    .CLK_10M    (CLK_10M),
    .nReset     (nReset),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_sof    (pix_sof),
    .pix_rgb    (pix_rgb),
    .gs_valid   (gs_valid),
    .gs_ready   (gs_ready),
    .gs_word    (gs_word),
    .drop_count (drop_count)
  );

  always #50 CLK_10M = ~CLK_10M;

  // Reference packing written independently of the RTL helpers.
  function automatic latch_word_t model_word();
    latch_word_t w = '0;
    for (int i = 0; i < 16; i++) begin
      w[48*i +: 48] = {grp[i][7:0], grp[i][7:0], grp[i][15:8], grp[i][15:8],
                       grp[i][23:16], grp[i][23:16]};
    end
    return w;
  endfunction

  always @(negedge CLK_10M) begin
    if (!nReset) begin
      seen_word = 1'b0;
    end else if (gs_valid) begin
      if (!seen_word) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL scoreboard_unexpected_word got %h", gs_word);
        end else begin
          mon_exp = exp_q.pop_front();
          if (gs_word !== mon_exp) begin
            tests_failed++;
            $display("FAIL scoreboard_word got %h exp %h", gs_word, mon_exp);
          end
        end
      end
      seen_word = !gs_ready;
    end else begin
      seen_word = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK_10M);
    #1;
  endtask

  // Holds the pixel until the DUT takes it; returns at posedge+1 of the accept.
  task automatic send_pix(input logic [23:0] rgb, input logic sof);
    int   waited = 0;
    logic acc = 1'b0;
    pix_valid = 1'b1;
    pix_rgb   = rgb;
    pix_sof   = sof;
    while (!acc && waited < 100) begin
      @(negedge CLK_10M);
      acc = pix_ready;
      @(posedge CLK_10M);
      #1;
      waited++;
    end
    if (!acc) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_pix_timeout pix_ready got %b exp 1", pix_ready);
    end
  endtask

  task automatic idle_pix();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    tick(2);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain pending words got %0d exp 0", tag, exp_q.size());
    end
  endtask

  task automatic send_grp(input int first);
    for (int i = first; i < 16; i++) send_pix(grp[i], 1'b0);
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    tick(3);
    tests_run += 4;
    if (pix_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_pix_ready got %b exp 1", pix_ready); end
    if (gs_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_gs_valid got %b exp 0", gs_valid); end
    if (gs_word !== '0) begin tests_failed++; $display("FAIL reset_gs_word got %h exp 0", gs_word); end
    if (drop_count !== 8'd0) begin tests_failed++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
    nReset = 1'b1;
    tick(2);
    tests_run += 2;
    if (pix_ready !== 1'b1) begin tests_failed++; $display("FAIL idle_pix_ready got %b exp 1", pix_ready); end
    if (gs_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_gs_valid got %b exp 0", gs_valid); end
    gs_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_pix(24'($urandom), 1'b0);
    idle_pix();
    nReset = 1'b0;
    tick(1);
    nReset = 1'b1;
    tick(1);
    for (int i = 0; i < 16; i++) grp[i] = 24'($urandom);
    exp_q.push_back(model_word());
    send_grp(0);
    idle_pix();
    wait_drain("reset_midgroup");
    tests_run++;
    if (drop_count !== 8'd0) begin tests_failed++; $display("FAIL reset_midgroup_drop got %0d exp 0", drop_count); end
  endtask

  task automatic test_solid_blue();
    gs_ready = 1'b1;
    for (int i = 0; i < 16; i++) grp[i] = 24'h0000FF;
    exp_q.push_back(model_word());
    send_grp(0);
    idle_pix();
    tests_run += 2;
    if (gs_valid !== 1'b0) begin tests_failed++; $display("FAIL blue_early_valid got %b exp 0", gs_valid); end
    if (pix_ready !== 1'b0) begin tests_failed++; $display("FAIL blue_full_ready got %b exp 0", pix_ready); end
    tick(1);
    tests_run += 4;
    if (gs_valid !== 1'b1) begin tests_failed++; $display("FAIL blue_latency_valid got %b exp 1", gs_valid); end
    if (gs_word[768] !== 1'b0) begin tests_failed++; $display("FAIL blue_select_bit got %b exp 0", gs_word[768]); end
    if (gs_word[47:0] !== 48'hFFFF_0000_0000) begin tests_failed++; $display("FAIL blue_led0 got %h exp ffff00000000", gs_word[47:0]); end
    if (gs_word[767:720] !== 48'hFFFF_0000_0000) begin tests_failed++; $display("FAIL blue_led15 got %h exp ffff00000000", gs_word[767:720]); end
    tick(1);
    tests_run++;
    if (gs_valid !== 1'b0) begin tests_failed++; $display("FAIL blue_pulse_width got %b exp 0", gs_valid); end
    wait_drain("blue");
  endtask

  task automatic test_led_index();
    gs_ready = 1'b1;
    for (int i = 0; i < 16; i++) grp[i] = {8'(i), 8'h80, 8'h01};
    exp_q.push_back(model_word());
    send_grp(0);
    idle_pix();
    tick(1);
    tests_run += 3;
    if (gs_valid !== 1'b1) begin tests_failed++; $display("FAIL index_valid got %b exp 1", gs_valid); end
    if (gs_word[47:0] !== {16'h0101, 16'h8080, 16'h0000}) begin tests_failed++; $display("FAIL index_led0 got %h exp 010180800000", gs_word[47:0]); end
    if (gs_word[767:720] !== {16'h0101, 16'h8080, 16'h0F0F}) begin tests_failed++; $display("FAIL index_led15 got %h exp 010180800f0f", gs_word[767:720]); end
    wait_drain("index");
  endtask

  task automatic test_backpressure();
    latch_word_t word_a, word_b;
    gs_ready = 1'b0;
    for (int i = 0; i < 16; i++) grp[i] = 24'($urandom);
    word_a = model_word();
    exp_q.push_back(word_a);
    send_grp(0);
    for (int i = 0; i < 16; i++) grp[i] = 24'($urandom);
    word_b = model_word();
    exp_q.push_back(word_b);
    send_grp(0);
    tests_run += 2;
    if (pix_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_after_32 got %b exp 0", pix_ready); end
    if (gs_word !== word_a) begin tests_failed++; $display("FAIL bp_first_word got %h exp %h", gs_word, word_a); end
    pix_valid = 1'b1;
    pix_rgb   = 24'hABCDEF;
    tick(3);
    tests_run += 3;
    if (pix_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_pix33_ready got %b exp 0", pix_ready); end
    if (gs_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_hold_valid got %b exp 1", gs_valid); end
    if (gs_word !== word_a) begin tests_failed++; $display("FAIL bp_hold_word got %h exp %h", gs_word, word_a); end
    idle_pix();
    gs_ready = 1'b1;
    tick(1);
    gs_ready = 1'b0;
    tests_run += 3;
    if (gs_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_second_valid got %b exp 1", gs_valid); end
    if (gs_word !== word_b) begin tests_failed++; $display("FAIL bp_second_word got %h exp %h", gs_word, word_b); end
    if (pix_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_release got %b exp 1", pix_ready); end
    gs_ready = 1'b1;
    wait_drain("backpressure");
  endtask

  task automatic test_sof();
    logic [23:0] last_sof;
    gs_ready = 1'b1;
    send_pix(24'($urandom), 1'b1);
    for (int i = 0; i < 4; i++) send_pix(24'($urandom), 1'b0);
    tests_run++;
    if (drop_count !== 8'(exp_drop)) begin tests_failed++; $display("FAIL sof_at_idx0 got %0d exp %0d", drop_count, exp_drop); end
    for (int i = 0; i < 16; i++) grp[i] = 24'($urandom);
    exp_q.push_back(model_word());
    send_pix(grp[0], 1'b1);
    exp_drop++;
    tests_run++;
    if (drop_count !== 8'(exp_drop)) begin tests_failed++; $display("FAIL sof_drop_one got %0d exp %0d", drop_count, exp_drop); end
    send_grp(1);
    idle_pix();
    wait_drain("sof");
    last_sof = '0;
    for (int k = 0; k < 300; k++) begin
      send_pix(24'($urandom), 1'b0);
      last_sof = 24'($urandom);
      send_pix(last_sof, 1'b1);
      if (exp_drop < 255) exp_drop++;
      if (k == 252 || k == 253 || k == 299) begin
        tests_run++;
        if (drop_count !== 8'(exp_drop)) begin tests_failed++; $display("FAIL sof_saturate_%0d got %0d exp %0d", k, drop_count, exp_drop); end
      end
    end
    grp[0] = last_sof;
    for (int i = 1; i < 16; i++) grp[i] = 24'($urandom);
    exp_q.push_back(model_word());
    send_grp(1);
    idle_pix();
    wait_drain("sof_tail");
    tests_run++;
    if (drop_count !== 8'd255) begin tests_failed++; $display("FAIL sof_final_drop got %0d exp 255", drop_count); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] px[64];
    int rises[$];
    int high_cycles = 0;
    gs_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 16; i++) begin
        grp[i] = 24'($urandom);
        px[16*g+i] = grp[i];
      end
      exp_q.push_back(model_word());
    end
    fork
      begin
        for (int i = 0; i < 64; i++) send_pix(px[i], 1'b0);
        idle_pix();
      end
      begin
        logic prev = 1'b0;
        for (int c = 0; c < 100; c++) begin
          @(negedge CLK_10M);
          if (gs_valid) high_cycles++;
          if (gs_valid && !prev) rises.push_back(c);
          prev = gs_valid;
        end
      end
    join
    tests_run += 2;
    if (rises.size() != 4) begin tests_failed++; $display("FAIL b2b_pulses got %0d exp 4", rises.size()); end
    if (high_cycles != 4) begin tests_failed++; $display("FAIL b2b_valid_cycles got %0d exp 4", high_cycles); end
    for (int i = 1; i < rises.size(); i++) begin
      tests_run++;
      if (rises[i] - rises[i-1] != 17) begin tests_failed++; $display("FAIL b2b_gap_%0d got %0d exp 17", i, rises[i] - rises[i-1]); end
    end
    wait_drain("b2b");
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog_timeout sim time got %0t exp below 5ms", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(1);
    test_reset();
    test_solid_blue();
    test_led_index();
    test_backpressure();
    test_sof();
    test_back_to_back();
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL final_queue got %0d exp 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
